// File: rtl/spi_control_fsm.sv
// ----------------------------------------------------------------------------
// spi_control_fsm
//
// Sequencing FSM for an SPI slave. It walks a transaction through an address
// phase, then either a read (memory read wait, shift-register load, MISO
// transmit) or a write (data receive, memory write). Every output is a Moore
// decode of the current state.
//
// Ports:
//   clk           sole clock, rising edge
//   reset         synchronous, active-high reset
//   cs            conditioned chip select, active low
//   sclk_posedge  one-clk pulse per conditioned SCLK rising edge
//   sclk_negedge  one-clk pulse per conditioned SCLK falling edge
//   rw_bit        shift-register LSB after the address phase (1 = read)
//   addr_we       address register write enable (GOT_ADDR)
//   sr_we         shift-register parallel load (READ_LOAD)
//   dm_we         data memory write enable (WRITE_MEM)
//   miso_buff     MISO tri-state enable (READ_TX)
//   state         current state encoding, for debug
//   busy          high in every state except IDLE
// ----------------------------------------------------------------------------
module spi_control_fsm #(
    parameter int bits = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       sclk_posedge,
    input  logic       sclk_negedge,
    input  logic       rw_bit,
    output logic       addr_we,
    output logic       sr_we,
    output logic       dm_we,
    output logic       miso_buff,
    output logic [3:0] state,
    output logic       busy
);

    localparam int CW = $clog2(bits + 1);
    // The terminal edge is the one that arrives while the count is bits-1;
    // the count itself never needs to reach bits because it clears on exit.
    localparam logic [CW-1:0] LAST = CW'(bits - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        GET_ADDR  = 4'd1,
        GOT_ADDR  = 4'd2,
        READ_WAIT = 4'd3,
        READ_LOAD = 4'd4,
        READ_TX   = 4'd5,
        WRITE_RX  = 4'd6,
        WRITE_MEM = 4'd7,
        DONE      = 4'd8
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // values that existed before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: both targets get a default before the case statement; without it
    // any path that skips an assignment would infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                if (!cs) state_d = GET_ADDR;
            end
            GET_ADDR: begin
                if (sclk_posedge) begin
                    if (count_q == LAST) state_d = GOT_ADDR;
                    else                 count_d = count_q + CW'(1);
                end
            end
            GOT_ADDR:  state_d = rw_bit ? READ_WAIT : WRITE_RX;
            READ_WAIT: state_d = READ_LOAD;
            READ_LOAD: state_d = READ_TX;
            READ_TX: begin
                // Data is shifted out on falling SCLK edges.
                if (sclk_negedge) begin
                    if (count_q == LAST) state_d = DONE;
                    else                 count_d = count_q + CW'(1);
                end
            end
            WRITE_RX: begin
                if (sclk_posedge) begin
                    if (count_q == LAST) state_d = WRITE_MEM;
                    else                 count_d = count_q + CW'(1);
                end
            end
            WRITE_MEM: state_d = DONE;
            DONE:      state_d = DONE;
            default:   state_d = IDLE;
        endcase

        // Deselect aborts from anywhere, including on a terminal-count edge.
        if (cs && state_q != IDLE) state_d = IDLE;

        // The counter measures progress within one state only.
        if (state_d != state_q) count_d = '0;
    end

    assign addr_we   = (state_q == GOT_ADDR);
    assign sr_we     = (state_q == READ_LOAD);
    assign dm_we     = (state_q == WRITE_MEM);
    assign miso_buff = (state_q == READ_TX);
    assign busy      = (state_q != IDLE);
    assign state     = state_q;

endmodule

// File: doc/spi_control_fsm.md
SPI_CONTROL_FSM -- requirements
Module: spi_control_fsm

Interface
REQ-001 SHALL have parameter: bits, default 8, number of SCLK bits per transaction phase (address phase and data phase), legal range 2..16.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: cs  input  1  conditioned chip select, active low.
REQ-005 SHALL have port: sclk_posedge  input  1  one-clk pulse marking a conditioned SCLK rising edge.
REQ-006 SHALL have port: sclk_negedge  input  1  one-clk pulse marking a conditioned SCLK falling edge.
REQ-007 SHALL have port: rw_bit  input  1  shift-register LSB; 1 = read, 0 = write.
REQ-008 SHALL have port: addr_we  output  1  wrenable for the downstream address register.
REQ-009 SHALL have port: sr_we  output  1  parallel-load enable for the shift register.
REQ-010 SHALL have port: dm_we  output  1  data memory write enable.
REQ-011 SHALL have port: miso_buff  output  1  MISO tri-state buffer enable.
REQ-012 SHALL have port: state  output  4  current state encoding, for debug.
REQ-013 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement these states: IDLE=0, GET_ADDR=1, GOT_ADDR=2, READ_WAIT=3, READ_LOAD=4, READ_TX=5, WRITE_RX=6, WRITE_MEM=7, DONE=8.
REQ-015 SHALL decode all outputs combinationally from state only (Moore): addr_we in GOT_ADDR; sr_we in READ_LOAD; miso_buff in READ_TX; dm_we in WRITE_MEM; otherwise 0.
REQ-016 SHALL hold a bit counter of ceil(log2(bits+1)) bits that clears on every state change.
REQ-017 IDLE: cs=0 -> GET_ADDR; otherwise stay in IDLE.
REQ-018 GET_ADDR: counter increments on each sclk_posedge; the sclk_posedge that brings the count to bits -> GOT_ADDR on the same edge.
REQ-019 GOT_ADDR: lasts exactly 1 clk; samples rw_bit; 1 -> READ_WAIT, 0 -> WRITE_RX.
REQ-020 READ_WAIT: lasts exactly 1 clk (memory read latency), then READ_LOAD.
REQ-021 READ_LOAD: lasts exactly 1 clk, then READ_TX.
REQ-022 READ_TX: counter increments on each sclk_negedge; the sclk_negedge that brings the count to bits -> DONE.
REQ-023 WRITE_RX: counter increments on each sclk_posedge; the sclk_posedge that brings the count to bits -> WRITE_MEM.
REQ-024 WRITE_MEM: lasts exactly 1 clk, then DONE.
REQ-025 DONE: hold until cs=1.
REQ-026 cs=1 in any non-IDLE state -> IDLE on the next edge, clearing the counter; this overrides all other transitions, including a terminal count edge in the same cycle.
REQ-027 If sclk_posedge and sclk_negedge are both high in one cycle, each counting state uses only its own edge input and ignores the other.
REQ-028 Edge pulses arriving in IDLE, GOT_ADDR, READ_WAIT, READ_LOAD, WRITE_MEM or DONE SHALL be ignored and not counted.
REQ-029 An unused state encoding SHALL go to IDLE on the next edge.

Reset
REQ-030 reset=1 at a clk edge -> state=IDLE, counter=0; addr_we, sr_we, dm_we, miso_buff all 0; busy=0. Reset overrides cs and the edge inputs.
REQ-031 reset mid-transaction SHALL abort without further dm_we or addr_we pulses; with cs=0 and reset released, the FSM re-enters GET_ADDR on the next edge.

Verification
REQ-032 Read: reset, cs=0, 8 posedges with rw_bit=1 -> addr_we 1 clk, then 1 idle clk, sr_we 1 clk, miso_buff high for exactly 8 negedges, then DONE; dm_we never asserts.
REQ-033 Write: 8 posedges with rw_bit=0, then 8 more posedges -> addr_we 1 clk, dm_we exactly 1 clk after the 16th posedge, then DONE; miso_buff never asserts.
REQ-034 Abort: cs goes high after 5 address posedges -> IDLE next clk, no write-enable pulses; next cs=0 restarts counting from 0.
REQ-035 Simultaneous: cs=1 in the same clk as the 8th WRITE_RX posedge -> IDLE, dm_we stays 0.
REQ-036 Reset during READ_TX after 3 negedges -> miso_buff=0 and state=0 the next clk.
REQ-037 Noise: sclk_negedge pulses during GET_ADDR and pulses during DONE -> no count change and no output change.
